// File: rtl/bist_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bist_pkg - BIST_CODE state encodings shared with the BIST decoder       |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
package bist_pkg;

  localparam int BIST_CODE_W = 5;

  typedef enum logic [BIST_CODE_W-1:0] {
    BC_IDLE      = 5'd0,
    BC_INIT      = 5'd1,
    BC_MEM_WR    = 5'd2,
    BC_CNT_INC   = 5'd3,
    BC_CNT_RST   = 5'd4,
    BC_VEC_LD    = 5'd5,
    BC_VEC_SHIFT = 5'd6,
    BC_VEC_APPLY = 5'd7,
    BC_BUF_LD    = 5'd8,
    BC_LOG_RST   = 5'd9,
    BC_LOG_CLK   = 5'd10,
    BC_SETTLE    = 5'd11,
    BC_CMP       = 5'd12,
    BC_ERR       = 5'd13,
    BC_FIN_RST   = 5'd14,
    BC_CLEANUP   = 5'd15,
    BC_DONE      = 5'd16
  } bist_code_e;

endpackage
`default_nettype wire

// File: rtl/bist_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bist_sequencer_if - RUNBIST control and decoder-facing status bundle    |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
interface bist_sequencer_if #(
  parameter int VEC_W     = 2,
  parameter int ERR_CNT_W = 8
);
  import bist_pkg::*;

  logic                   BIST_start;
  logic                   BIST_abort;
  logic                   Cmp_mismatch;
  logic [BIST_CODE_W-1:0] BIST_CODE;
  logic                   BIST_busy;
  logic                   BIST_done;
  logic                   BIST_fail;
  logic [ERR_CNT_W-1:0]   Err_count;
  logic [VEC_W-1:0]       Vec_index;

  modport master (
    input  BIST_start, BIST_abort, Cmp_mismatch,
    output BIST_CODE, BIST_busy, BIST_done, BIST_fail, Err_count, Vec_index
  );

  modport slave (
    output BIST_start, BIST_abort, Cmp_mismatch,
    input  BIST_CODE, BIST_busy, BIST_done, BIST_fail, Err_count, Vec_index
  );
endinterface
`default_nettype wire

// File: rtl/bist_wait_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bist_wait_timer - loadable down-counter with zero flag                  |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module bist_wait_timer #(
  parameter int W = 2
) (
  input  wire logic         clk_i,
  input  wire logic         res_n_i,
  input  wire logic         load_i,
  input  wire logic [W-1:0] load_val_i,
  output logic              zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/bist_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bist_sequencer - BIST master FSM: fill, per-vector test loop, cleanup   |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int NUM_VECTORS    = 4,
  parameter int VEC_W          = 2,
  parameter int LOG_CLK_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int ERR_CNT_W      = 8
) (
  input  wire logic         BIST_clk,
  input  wire logic         BIST_res_n,
  bist_sequencer_if.master  bus
);

  localparam int TMR_MAX = (LOG_CLK_CYCLES > SETTLE_CYCLES) ? LOG_CLK_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

  bist_code_e           code_q, code_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 fail_q, fail_d;
  logic                 aborted_q, aborted_d;
  logic                 busy_q, done_q;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_zero;
  logic                 vec_last;
  bist_code_e           adv_code;
  logic [VEC_W-1:0]     adv_vec;

  bist_wait_timer #(.W(TMR_W)) u_timer (
    .clk_i      (BIST_clk),
    .res_n_i    (BIST_res_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign vec_last = (vec_q == VEC_LAST);
  assign adv_code = vec_last ? BC_FIN_RST : BC_VEC_LD;
  assign adv_vec  = vec_last ? vec_q : vec_q + 1'b1;

  always_comb begin
    code_d    = code_q;
    vec_d     = vec_q;
    err_d     = err_q;
    fail_d    = fail_q;
    aborted_d = aborted_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (code_q)
      BC_IDLE: if (bus.BIST_start) begin
        code_d = BC_INIT;
        vec_d  = '0;
        err_d  = '0;
        fail_d = 1'b0;
      end
      BC_INIT:      code_d = BC_MEM_WR;
      BC_MEM_WR:    code_d = BC_CNT_INC;
      BC_CNT_INC: begin
        code_d = vec_last ? BC_CNT_RST : BC_MEM_WR;
        vec_d  = vec_last ? '0 : vec_q + 1'b1;
      end
      BC_CNT_RST:   code_d = BC_VEC_LD;
      BC_VEC_LD:    code_d = BC_VEC_SHIFT;
      BC_VEC_SHIFT: code_d = BC_VEC_APPLY;
      BC_VEC_APPLY: code_d = BC_BUF_LD;
      BC_BUF_LD:    code_d = BC_LOG_RST;
      BC_LOG_RST: begin
        code_d   = BC_LOG_CLK;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(LOG_CLK_CYCLES - 1);
      end
      BC_LOG_CLK: if (tmr_zero) begin
        code_d   = BC_SETTLE;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
      end
      BC_SETTLE: if (tmr_zero) code_d = BC_CMP;
      BC_CMP: begin
        if (bus.Cmp_mismatch) begin
          code_d = BC_ERR;
          fail_d = 1'b1;
          if (!(&err_q)) err_d = err_q + 1'b1;
        end else begin
          code_d = adv_code;
          vec_d  = adv_vec;
        end
      end
      BC_ERR: begin
        code_d = adv_code;
        vec_d  = adv_vec;
      end
      BC_FIN_RST: code_d = BC_CLEANUP;
      BC_CLEANUP: begin
        code_d    = aborted_q ? BC_IDLE : BC_DONE;
        aborted_d = 1'b0;
      end
      BC_DONE: if (!bus.BIST_start) code_d = BC_IDLE;
      default: begin
        code_d    = BC_IDLE;
        aborted_d = 1'b0;
      end
    endcase

    // Abort discards whatever the normal transition computed, including a pending error count.
    if (bus.BIST_abort && (code_q >= BC_INIT) && (code_q <= BC_FIN_RST)) begin
      code_d    = BC_CLEANUP;
      aborted_d = 1'b1;
      vec_d     = vec_q;
      err_d     = err_q;
      fail_d    = fail_q;
      tmr_load  = 1'b0;
    end
  end

  always_ff @(posedge BIST_clk) begin
    if (!BIST_res_n) begin
      code_q    <= BC_IDLE;
      vec_q     <= '0;
      err_q     <= '0;
      fail_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      code_q    <= code_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      aborted_q <= aborted_d;
      busy_q    <= (code_d != BC_IDLE) && (code_d != BC_DONE);
      done_q    <= (code_d == BC_DONE);
    end
  end

  assign bus.BIST_CODE = code_q;
  assign bus.Vec_index = vec_q;
  assign bus.Err_count = err_q;
  assign bus.BIST_fail = fail_q;
  assign bus.BIST_busy = busy_q;
  assign bus.BIST_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bist_sequencer - random-mask runs checked against a code-trace model |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module tb_bist_sequencer;
  import bist_pkg::*;

  localparam int N = 4;
  localparam int L = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mism = 1'b0;

  int checks = 0;
  int failures = 0;

  int q_code[$];
  int q_vec[$];
  int q_err[$];

  always #5 clk = ~clk;

  bist_sequencer_if #(.VEC_W(2), .ERR_CNT_W(8)) if_a ();
  bist_sequencer_if #(.VEC_W(2), .ERR_CNT_W(1)) if_b ();

  assign if_a.BIST_start   = start;
  assign if_a.BIST_abort   = abort;
  assign if_a.Cmp_mismatch = mism;
  assign if_b.BIST_start   = start;
  assign if_b.BIST_abort   = abort;
  assign if_b.Cmp_mismatch = mism;

  bist_sequencer #(.NUM_VECTORS(N), .VEC_W(2), .LOG_CLK_CYCLES(L),
                   .SETTLE_CYCLES(S), .ERR_CNT_W(8)) u_dut_a (
    .BIST_clk   (clk),
    .BIST_res_n (res_n),
    .bus        (if_a.master)
  );

  bist_sequencer #(.NUM_VECTORS(N), .VEC_W(2), .LOG_CLK_CYCLES(L),
                   .SETTLE_CYCLES(S), .ERR_CNT_W(1)) u_dut_b (
    .BIST_clk   (clk),
    .BIST_res_n (res_n),
    .bus        (if_b.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int c, input int v, input int e);
    q_code.push_back(c);
    q_vec.push_back(v);
    q_err.push_back(e);
  endfunction

  // Entry k is the expected state just after the k-th rising edge of the run.
  function automatic void build(input logic [3:0] mask, input int abort_k,
                                input int reset_k, output bit normal);
    int e = 0;
    q_code.delete(); q_vec.delete(); q_err.delete();
    push(0, 0, 0);
    push(1, 0, 0);
    for (int v = 0; v < N; v++) begin
      push(2, v, 0);
      push(3, v, 0);
    end
    push(4, 0, 0);
    for (int v = 0; v < N; v++) begin
      for (int c = 5; c <= 9; c++) push(c, v, e);
      for (int i = 0; i < L; i++) push(10, v, e);
      for (int i = 0; i < S; i++) push(11, v, e);
      push(12, v, e);
      if (mask[v]) begin
        e++;
        push(13, v, e);
      end
    end
    push(14, N-1, e);
    push(15, N-1, e);
    push(16, N-1, e);
    normal = 1'b1;
    if (reset_k > 0) begin
      while (q_code.size() > reset_k) begin
        void'(q_code.pop_back()); void'(q_vec.pop_back()); void'(q_err.pop_back());
      end
      push(0, 0, 0);
      normal = 1'b0;
    end else if (abort_k >= 2 && abort_k < q_code.size() &&
                 q_code[abort_k-1] >= 1 && q_code[abort_k-1] <= 14) begin
      int av = q_vec[abort_k-1];
      int ae = q_err[abort_k-1];
      while (q_code.size() > abort_k) begin
        void'(q_code.pop_back()); void'(q_vec.pop_back()); void'(q_err.pop_back());
      end
      push(15, av, ae);
      push(0, av, ae);
      normal = 1'b0;
    end
    if (normal) begin
      push(16, N-1, e);
      push(16, N-1, e);
      push(0, N-1, e);
    end
  endfunction

  task automatic run(input logic [3:0] mask, input int abort_k, input int reset_k, input string name);
    bit normal;
    int first16 = -1;
    int last;
    build(mask, abort_k, reset_k, normal);
    last = q_code.size() - 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start = !(normal && k == last);
      abort = (k == abort_k);
      res_n = !(k == reset_k);
      mism  = (q_code[k-1] == 12) ? mask[q_vec[k-1]] : 1'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] code", name, k), 32'(if_a.BIST_CODE), q_code[k]);
      check($sformatf("%s[%0d] vec", name, k), 32'(if_a.Vec_index), q_vec[k]);
      check($sformatf("%s[%0d] err", name, k), 32'(if_a.Err_count),
            (q_err[k] > 255) ? 255 : q_err[k]);
      check($sformatf("%s[%0d] fail", name, k), 32'(if_a.BIST_fail), 32'(q_err[k] > 0));
      check($sformatf("%s[%0d] busy", name, k), 32'(if_a.BIST_busy),
            32'(q_code[k] != 0 && q_code[k] != 16));
      check($sformatf("%s[%0d] done", name, k), 32'(if_a.BIST_done), 32'(q_code[k] == 16));
      check($sformatf("%s[%0d] sat_code", name, k), 32'(if_b.BIST_CODE), q_code[k]);
      check($sformatf("%s[%0d] sat_err", name, k), 32'(if_b.Err_count),
            (q_err[k] > 1) ? 1 : q_err[k]);
      check($sformatf("%s[%0d] sat_fail", name, k), 32'(if_b.BIST_fail), 32'(q_err[k] > 0));
      if (first16 < 0 && if_a.BIST_CODE == 5'd16) first16 = k;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    res_n = 1'b1;
    mism  = 1'b0;
    if (normal)
      check($sformatf("%s edges_to_done", name), first16,
            1 + 2*N + 1 + N*(6 + L + S) + $countones(mask) + 2 + 1);
  endtask

  initial begin
    res_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset code", 32'(if_a.BIST_CODE), 0);
    check("reset vec", 32'(if_a.Vec_index), 0);
    check("reset err", 32'(if_a.Err_count), 0);
    check("reset fail", 32'(if_a.BIST_fail), 0);
    check("reset busy", 32'(if_a.BIST_busy), 0);
    check("reset done", 32'(if_a.BIST_done), 0);

    run(4'b0000, 0, 0, "clean");
    run(4'b1010, 0, 0, "mism13");
    run(4'b1111, 0, 0, "saturate");
    run(4'b0000, 0, 0, "rerun_clean");
    // Vectors 0 and 1 mismatch, so code 10 of vector 2 starts at entry 42.
    run(4'b0011, 43, 0, "abort_v2");
    // Reset lands on the code-3 cycle of the third fill word.
    run(4'b0101, 0, 8, "reset_fill");
    run(4'b0110, 0, 0, "after_reset");
    for (int r = 0; r < 6; r++) begin
      logic [3:0] m;
      int ak;
      m  = 4'($urandom);
      ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 70)) : 0;
      run(m, ak, 0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
